// File: rtl/pipeline_if.sv
// Shared pipeline definitions: per-stage payload structs and the latch widths
// derived from them, plus a small helper used by the stage latch.
package pipeline_if;

    // Fetch -> decode payload.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ifetch_t;

    // Decode -> execute payload.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [3:0]  alu_op;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } decode_t;

    // Execute -> memory payload.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu_res;
        logic [31:0] store_val;
        logic [4:0]  rd;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
    } exec_t;

    // Memory -> writeback payload.
    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        reg_we;
    } mem_t;

    // Widths handed to each pipe_stage instance between adjacent stages.
    localparam int IFID_W  = $bits(ifetch_t);
    localparam int IDEX_W  = $bits(decode_t);
    localparam int EXMEM_W = $bits(exec_t);
    localparam int MEMWB_W = $bits(mem_t);

    // Number of valid entries held by a two-slot latch.
    function automatic logic [1:0] entry_count(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_stall_counter.sv
// Saturating up-counter with synchronous clear; used to count stalled cycles
// of a pipeline latch for performance debug.
module pipe_stall_counter
    import pipeline_if::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Clear wins over increment; the count parks at all-ones instead of wrapping.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stage.sv
// Generic pipeline latch between two adjacent stages. Carries an opaque
// payload with a valid/ready handshake. With SKID=1 a second entry absorbs
// one extra payload so in_ready can come straight from a flop; with SKID=0 a
// single register is used and in_ready depends combinationally on out_ready.
module pipe_stage
    import pipeline_if::*;
#(
    parameter int WIDTH = 32,
    parameter bit SKID  = 1'b1,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    input  logic             stall_clr,
    output logic [CNT_W-1:0] stall_count
);

    // Main (head) entry, always the one presented downstream.
    logic             m_valid;
    logic [WIDTH-1:0] m_data;
    // Skid entry; only ever occupied while the main entry is held.
    logic             s_valid;

    logic push;
    logic pop;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    assign out_valid = m_valid;
    assign out_data  = m_data;
    assign occupancy = entry_count(m_valid, s_valid);

    generate
        if (SKID) begin : g_skid
            logic [WIDTH-1:0] s_data;

            // s_valid is a flop, so upstream never sees a path from out_ready.
            assign in_ready = !s_valid;

            // Head entry: refill from skid first so order stays FIFO, else from input.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                end else if (!m_valid || pop) begin
                    if (s_valid) begin
                        m_valid <= 1'b1;
                        m_data  <= s_data;
                    end else begin
                        m_valid <= push;
                        if (push) begin
                            m_data <= in_data;
                        end
                    end
                end
            end

            // Skid entry: catches a push that arrives while the head is held.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    s_valid <= 1'b0;
                    s_data  <= '0;
                end else if (flush) begin
                    s_valid <= 1'b0;
                end else if (!m_valid || pop) begin
                    s_valid <= 1'b0;
                end else if (push) begin
                    s_valid <= 1'b1;
                    s_data  <= in_data;
                end
            end
        end else begin : g_single
            // Single register: accept whenever the head is empty or leaving now.
            assign in_ready = !m_valid | out_ready;
            assign s_valid  = 1'b0;

            // Head entry: load on push, drain on pop, drop everything on flush.
            always_ff @(posedge CLK or negedge nRST) begin
                if (!nRST) begin
                    m_valid <= 1'b0;
                    m_data  <= '0;
                end else if (flush) begin
                    m_valid <= 1'b0;
                end else if (push) begin
                    m_valid <= 1'b1;
                    m_data  <= in_data;
                end else if (pop) begin
                    m_valid <= 1'b0;
                end
            end
        end
    endgenerate

    pipe_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .CLK   (CLK),
        .nRST  (nRST),
        .clr   (stall_clr),
        .inc   (out_valid & ~out_ready),
        .count (stall_count)
    );

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: one skid instance (narrow stall counter) and one
// single-register instance. Stimulus pushes expected payloads into per-DUT
// queues; a monitor pops and compares whenever a DUT hands a payload on.
module tb_pipe_stage;

    logic CLK;
    logic nRST;

    // Skid instance
    logic        flush1, in_valid1, in_ready1, out_valid1, out_ready1, stall_clr1;
    logic [31:0] in_data1, out_data1;
    logic [1:0]  occupancy1;
    logic [1:0]  stall_count1;

    // Single-register instance
    logic        flush0, in_valid0, in_ready0, out_valid0, out_ready0, stall_clr0;
    logic [31:0] in_data0, out_data0;
    logic [1:0]  occupancy0;
    logic [15:0] stall_count0;

    logic [31:0] exp_q1[$];
    logic [31:0] exp_q0[$];

    int n_cmp;
    int n_bad;

    pipe_stage #(.WIDTH(32), .SKID(1'b1), .CNT_W(2)) dut1 (
        .CLK(CLK), .nRST(nRST), .flush(flush1),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .occupancy(occupancy1), .stall_clr(stall_clr1), .stall_count(stall_count1)
    );

    pipe_stage #(.WIDTH(32), .SKID(1'b0), .CNT_W(16)) dut0 (
        .CLK(CLK), .nRST(nRST), .flush(flush0),
        .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
        .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
        .occupancy(occupancy0), .stall_clr(stall_clr0), .stall_count(stall_count0)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor: a transfer completes at the next edge when valid & ready.
    always @(negedge CLK) begin
        if (nRST) begin
            if (out_valid1 && out_ready1) begin
                if (exp_q1.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL skid_unexpected: got 0x%0h expected no output", out_data1);
                end else begin
                    check("skid_data", out_data1, exp_q1.pop_front());
                end
            end
            if (out_valid0 && out_ready0) begin
                if (exp_q0.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL single_unexpected: got 0x%0h expected no output", out_data0);
                end else begin
                    check("single_data", out_data0, exp_q0.pop_front());
                end
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        nRST = 1'b0;
        {flush1, in_valid1, out_ready1, stall_clr1} = '0;
        {flush0, in_valid0, out_ready0, stall_clr0} = '0;
        in_data1 = '0;
        in_data0 = '0;

        // Reset values, before any clock edge.
        #3;
        check("rst_out_valid", {31'd0, out_valid1}, 32'd0);
        check("rst_out_data", out_data1, 32'd0);
        check("rst_occupancy", {30'd0, occupancy1}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready1}, 32'd1);
        check("rst_stall_count", {30'd0, stall_count1}, 32'd0);
        check("rst_in_ready_single", {31'd0, in_ready0}, 32'd1);
        step();
        step();
        nRST = 1'b1;
        step();

        // Streaming with out_ready=1: occupancy and in_ready stay at 1.
        out_ready1 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_valid1 = 1'b1;
            in_data1  = i;
            exp_q1.push_back(i);
            step();
            check("stream_occupancy", {30'd0, occupancy1}, 32'd1);
            check("stream_in_ready", {31'd0, in_ready1}, 32'd1);
        end
        in_valid1 = 1'b0;
        step();
        check("stream_drained", {30'd0, occupancy1}, 32'd0);

        // Backpressure: fill both entries, then drain in order.
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        in_data1   = 32'hA;
        exp_q1.push_back(32'hA);
        step();
        in_data1 = 32'hB;
        exp_q1.push_back(32'hB);
        step();
        in_valid1 = 1'b0;
        check("bp_occupancy", {30'd0, occupancy1}, 32'd2);
        check("bp_in_ready", {31'd0, in_ready1}, 32'd0);
        check("bp_head", out_data1, 32'hA);
        step();
        check("bp_head_stable", out_data1, 32'hA);
        out_ready1 = 1'b1;
        step();
        check("bp_in_ready_back", {31'd0, in_ready1}, 32'd1);
        check("bp_occupancy_one", {30'd0, occupancy1}, 32'd1);
        step();
        check("bp_drained", {30'd0, occupancy1}, 32'd0);

        // Flush wins over a push in the same cycle; 0xC must never emerge.
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        in_data1   = 32'h11;
        step();
        in_data1 = 32'h22;
        step();
        check("flush_pre_occupancy", {30'd0, occupancy1}, 32'd2);
        flush1   = 1'b1;
        in_data1 = 32'hC;
        step();
        flush1    = 1'b0;
        in_valid1 = 1'b0;
        check("flush_occupancy", {30'd0, occupancy1}, 32'd0);
        check("flush_out_valid", {31'd0, out_valid1}, 32'd0);
        out_ready1 = 1'b1;
        step();
        step();

        // Saturating stall counter (2 bits) and clear priority.
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        in_data1   = 32'h5;
        stall_clr1 = 1'b1;
        exp_q1.push_back(32'h5);
        step();
        in_valid1  = 1'b0;
        stall_clr1 = 1'b0;
        check("stall_start", {30'd0, stall_count1}, 32'd0);
        for (int i = 1; i <= 5; i++) begin
            step();
            check("stall_count", {30'd0, stall_count1}, (i > 3) ? 32'd3 : i);
        end
        stall_clr1 = 1'b1;
        step();
        check("stall_clear", {30'd0, stall_count1}, 32'd0);
        stall_clr1 = 1'b0;
        out_ready1 = 1'b1;
        step();
        check("stall_no_inc_on_pop", {30'd0, stall_count1}, 32'd0);
        step();

        // Reset between edges with both entries full.
        out_ready1 = 1'b0;
        in_valid1  = 1'b1;
        in_data1   = 32'hDEADBEEF;
        step();
        in_data1 = 32'h12345678;
        step();
        in_valid1 = 1'b0;
        step();
        check("midrst_pre_occupancy", {30'd0, occupancy1}, 32'd2);
        #2;
        nRST = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid1}, 32'd0);
        check("midrst_occupancy", {30'd0, occupancy1}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready1}, 32'd1);
        check("midrst_stall_count", {30'd0, stall_count1}, 32'd0);
        check("midrst_out_data", out_data1, 32'd0);
        step();
        nRST = 1'b1;
        step();

        // Single-register variant: push into a stage that pops in the same cycle.
        in_valid0 = 1'b1;
        in_data0  = 32'h6;
        exp_q0.push_back(32'h6);
        step();
        in_valid0 = 1'b0;
        #1;
        check("single_full_not_ready", {31'd0, in_ready0}, 32'd0);
        out_ready0 = 1'b1;
        in_valid0  = 1'b1;
        in_data0   = 32'h7;
        exp_q0.push_back(32'h7);
        #1;
        check("single_comb_ready", {31'd0, in_ready0}, 32'd1);
        step();
        in_valid0 = 1'b0;
        check("single_next_data", out_data0, 32'h7);
        check("single_occupancy", {30'd0, occupancy0}, 32'd1);
        step();
        check("single_drained", {30'd0, occupancy0}, 32'd0);
        check("single_stall_count", {16'd0, stall_count0}, 32'd0);
        step();

        check("skid_queue_empty", exp_q1.size(), 32'd0);
        check("single_queue_empty", exp_q0.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Clear the scoreboard when a flush or reset discards held entries.
    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            exp_q1.delete();
            exp_q0.delete();
        end else if (flush1) begin
            exp_q1.delete();
        end
    end

endmodule

// File: doc/pipe_stage.md
Name: pipe_stage

Overview:
- Generic, parametrised pipeline latch that replaces the hand-written per-stage latches (fetch/decode, decode/execute, execute/memory, memory/writeback).
- Carries an opaque WIDTH-bit payload (a packed stage struct) with a valid/ready handshake, an optional two-entry skid buffer, synchronous flush and a saturating stall counter for performance debug.
- Each instance sits between two adjacent pipeline stages.

Parameters:
- WIDTH, 32, payload width in bits; instantiated with the bit width of the stage struct.
- SKID, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- CNT_W, 16, width of the stall counter.

Ports:
- CLK input 1: clock, rising edge.
- nRST input 1: asynchronous, active-low reset.
- flush input 1: discard all held entries at the next edge.
- in_valid input 1: upstream presents payload.
- in_ready output 1: stage accepts payload this cycle.
- in_data input WIDTH: upstream payload.
- out_valid output 1: stage holds a valid payload.
- out_ready input 1: downstream accepts payload this cycle.
- out_data output WIDTH: head payload.
- occupancy output 2: number of held entries, 0..2.
- stall_clr input 1: synchronous clear of stall_count.
- stall_count output CNT_W: cycles with out_valid=1 and out_ready=0, saturating.

Behaviour:
- Reset (nRST=0): takes effect immediately and is independent of CLK.
  - Main entry M and skid entry S: valid=0, data=0.
  - stall_count=0; out_valid=0; out_data=0; occupancy=0; in_ready=1.
  - Reset during a transfer drops all held data.
- Definitions: push = in_valid & in_ready; pop = out_valid & out_ready; out_valid = M.valid; out_data = M.data.
- Latency: 1 cycle from push into an empty stage to out_valid. Sustained throughput is 1 payload per cycle.
- in_data is sampled only on push. out_data holds stable while out_valid=1 and out_ready=0.
- SKID=1:
  - in_ready = !S.valid, a register output with no combinational path from out_ready.
  - flush=1: M.valid<=0 and S.valid<=0. A push in the same cycle is dropped. Flush wins over push and pop.
  - Else, if !M.valid or pop:
    - If S.valid: M<=S and S.valid<=0 (push is impossible because in_ready=0).
    - Otherwise: M.valid<=push, and M.data<=in_data when push.
  - Else (M held, no pop): if push, S<=in_data and S.valid<=1.
  - Full (S.valid=1): in_ready=0. in_ready returns to 1 on the cycle after the pop that drains S into M.
  - Payload order is strictly FIFO: S never overtakes M.
- SKID=0:
  - S is absent. in_ready = !M.valid | out_ready (combinational).
  - On push, M<=in_data and M.valid<=1. Otherwise, on pop, M.valid<=0.
  - Flush behaves as in SKID=1.
- occupancy = M.valid + S.valid.
- stall_count:
  - Increments at each edge where out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 with no wrap.
  - stall_clr=1 forces 0, with priority over increment.
  - flush does not affect it.
- Data fields of invalid entries are don't-care, except that they are zeroed at reset.

Decomposition:
- The shared package pipeline_if keeps the stage structs and adds localparams for the stage widths:
  - IFID_W = $bits(ifetch_t)
  - IDEX_W = $bits(decode_t)
  - EXMEM_W = $bits(exec_t)
  - MEMWB_W = $bits(mem_t)
- Top level instantiates pipe_stage with these widths.
- One sub-module: pipe_stall_counter (saturating counter with synchronous clear, parameter CNT_W).

Test Plan:
- Reset mid-stream: hold M=0xDEADBEEF and S=0x12345678, assert nRST=0 between edges -> out_valid=0, occupancy=0, in_ready=1, stall_count=0 immediately.
- Streaming, SKID=1: push 0x1,0x2,0x3 on consecutive cycles with out_ready=1 -> out_data 0x1,0x2,0x3 on cycles 1,2,3; occupancy stays 1; in_ready stays 1.
- Backpressure: push 0xA then 0xB while out_ready=0 -> occupancy=2, in_ready=0, out_data=0xA held. Raise out_ready -> out_data=0xA, then 0xB; in_ready=1 one cycle after the first pop.
- Flush vs push: occupancy=2 with flush=1 and in_valid=1, in_data=0xC -> next cycle occupancy=0, out_valid=0. 0xC never appears.
- Stall counter, CNT_W=2: out_valid=1, out_ready=0 for 5 cycles -> stall_count 1,2,3,3,3. stall_clr with a stall present -> 0.
- SKID=0: out_valid=1, out_ready=1, push 0x7 in the same cycle -> in_ready=1 combinationally; next cycle out_data=0x7, occupancy=1.
